// File: rtl/postif_id_pkg.sv
// Shared definitions for the postif/id pipeline boundary: state encodings,
// bubble instruction and fetch exception-vector bit positions.
package postif_id_pkg;

    typedef enum logic [1:0] {
        PIF_EMPTY   = 2'd0,
        PIF_FULL    = 2'd1,
        PIF_DISCARD = 2'd2
    } pif_state_e;

    localparam logic [31:0] PIF_NOP_INST = 32'h0000_0000;

    // Fetch-side exception bits carried in the exception vector
    localparam int EXC_ADEL_BIT = 4;
    localparam int EXC_TLBL_BIT = 5;

endpackage

// File: rtl/postif_id_chk.sv
// Protocol checks for the postif/id boundary; holds assertions only.
module postif_id_chk
    import postif_id_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic [1:0] state,
    input  logic       beat,
    input  logic       buf_valid
);

    // The stall request must keep postif from delivering a beat while the buffer is occupied
    a_no_beat_when_full: assert property (@(posedge clk) disable iff (!resetn)
        (!flush && state == PIF_FULL) |-> !beat);

    // Buffer occupancy tracks the FULL state exactly
    a_buf_matches_state: assert property (@(posedge clk) disable iff (!resetn)
        buf_valid == (state == PIF_FULL));

endmodule

// File: rtl/postif_id_skid.sv
// One-entry holding buffer for a {pc, inst, exc} beat returned while id stalls.
module postif_id_skid
    import postif_id_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic [EXC_W-1:0]  exc_in,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst,
    output logic [EXC_W-1:0]  exc
);

    logic              valid_r;
    logic [PC_W-1:0]   pc_r;
    logic [INST_W-1:0] inst_r;
    logic [EXC_W-1:0]  exc_r;

    // Buffer storage: reset and clear empty it, load captures a beat
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
            exc_r   <= '0;
        end else if (clear) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
            exc_r   <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= pc_in;
            inst_r  <= inst_in;
            exc_r   <= exc_in;
        end else begin
            valid_r <= valid_r;
            pc_r    <= pc_r;
            inst_r  <= inst_r;
            exc_r   <= exc_r;
        end
    end

    assign valid = valid_r;
    assign pc    = pc_r;
    assign inst  = inst_r;
    assign exc   = exc_r;

endmodule

// File: rtl/postif_id.sv
// Post-fetch to decode pipeline register: completes the I-cache return, skids one
// beat while id stalls and drops a fetch that a flush has orphaned.
module postif_id
    import postif_id_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter int                EXC_W    = 32,
    parameter logic [INST_W-1:0] NOP_INST = PIF_NOP_INST[INST_W-1:0]
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_valid_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [EXC_W-1:0]  exception_type_i,
    input  logic              inst_stall_i,
    input  logic              id_stall_i,
    input  logic              flush_i,
    output logic              id_valid_o,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [EXC_W-1:0]  id_exception_type_o,
    output logic              stall_req_o
);

    pif_state_e        state_r, state_nxt_s;
    logic              id_valid_r, id_valid_nxt_s;
    logic [PC_W-1:0]   id_pc_r, id_pc_nxt_s;
    logic [INST_W-1:0] id_inst_r, id_inst_nxt_s;
    logic [EXC_W-1:0]  id_exc_r, id_exc_nxt_s;

    logic              exc_nz_s, beat_s, miss_s, ret_s;
    logic [INST_W-1:0] beat_inst_s;
    logic              skid_load_s, skid_clear_s, skid_valid_s;
    logic [PC_W-1:0]   skid_pc_s;
    logic [INST_W-1:0] skid_inst_s;
    logic [EXC_W-1:0]  skid_exc_s;

    // A faulting fetch never touched the cache, so it completes at once as a NOP
    assign exc_nz_s    = |exception_type_i;
    assign beat_s      = fetch_valid_i & (~inst_stall_i | exc_nz_s);
    assign miss_s      = fetch_valid_i & inst_stall_i & ~exc_nz_s;
    assign ret_s       = fetch_valid_i & ~inst_stall_i;
    assign beat_inst_s = exc_nz_s ? NOP_INST : inst_i;

    postif_id_skid #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .EXC_W  (EXC_W)
    ) u_skid (
        .clk     (clk),
        .resetn  (resetn),
        .load    (skid_load_s),
        .clear   (skid_clear_s),
        .pc_in   (pc_i),
        .inst_in (beat_inst_s),
        .exc_in  (exception_type_i),
        .valid   (skid_valid_s),
        .pc      (skid_pc_s),
        .inst    (skid_inst_s),
        .exc     (skid_exc_s)
    );

    // Next-state, id register and buffer control; flush overrides the state actions
    always_comb begin
        state_nxt_s    = state_r;
        id_valid_nxt_s = id_valid_r;
        id_pc_nxt_s    = id_pc_r;
        id_inst_nxt_s  = id_inst_r;
        id_exc_nxt_s   = id_exc_r;
        skid_load_s    = 1'b0;
        skid_clear_s   = 1'b0;
        if (flush_i) begin
            id_valid_nxt_s = 1'b0;
            id_inst_nxt_s  = NOP_INST;
            id_exc_nxt_s   = '0;
            skid_clear_s   = 1'b1;
            state_nxt_s    = miss_s ? PIF_DISCARD : PIF_EMPTY;
        end else begin
            case (state_r)
                PIF_EMPTY: begin
                    if (!id_stall_i) begin
                        if (beat_s) begin
                            id_valid_nxt_s = 1'b1;
                            id_pc_nxt_s    = pc_i;
                            id_inst_nxt_s  = beat_inst_s;
                            id_exc_nxt_s   = exception_type_i;
                        end else begin
                            id_valid_nxt_s = 1'b0;
                            id_inst_nxt_s  = NOP_INST;
                            id_exc_nxt_s   = '0;
                        end
                    end else if (beat_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = PIF_FULL;
                    end else begin
                        state_nxt_s = PIF_EMPTY;
                    end
                end
                PIF_FULL: begin
                    if (!id_stall_i) begin
                        id_valid_nxt_s = 1'b1;
                        id_pc_nxt_s    = skid_pc_s;
                        id_inst_nxt_s  = skid_inst_s;
                        id_exc_nxt_s   = skid_exc_s;
                        skid_clear_s   = 1'b1;
                        state_nxt_s    = PIF_EMPTY;
                    end else begin
                        state_nxt_s = PIF_FULL;
                    end
                end
                PIF_DISCARD: begin
                    if (!id_stall_i) begin
                        id_valid_nxt_s = 1'b0;
                        id_inst_nxt_s  = NOP_INST;
                        id_exc_nxt_s   = '0;
                    end else begin
                        id_valid_nxt_s = id_valid_r;
                    end
                    if (ret_s) begin
                        state_nxt_s = PIF_EMPTY;
                    end else begin
                        state_nxt_s = PIF_DISCARD;
                    end
                end
                default: begin
                    id_valid_nxt_s = 1'b0;
                    id_inst_nxt_s  = NOP_INST;
                    id_exc_nxt_s   = '0;
                    skid_clear_s   = 1'b1;
                    state_nxt_s    = PIF_EMPTY;
                end
            endcase
        end
    end

    // State and id output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= PIF_EMPTY;
            id_valid_r <= 1'b0;
            id_pc_r    <= '0;
            id_inst_r  <= NOP_INST;
            id_exc_r   <= '0;
        end else begin
            state_r    <= state_nxt_s;
            id_valid_r <= id_valid_nxt_s;
            id_pc_r    <= id_pc_nxt_s;
            id_inst_r  <= id_inst_nxt_s;
            id_exc_r   <= id_exc_nxt_s;
        end
    end

    // Hold pc/postif while anything downstream or the cache is not ready
    always_comb begin
        if (flush_i) begin
            stall_req_o = 1'b0;
        end else begin
            stall_req_o = (state_r == PIF_FULL) | id_stall_i | miss_s |
                          (state_r == PIF_DISCARD);
        end
    end

    assign id_valid_o          = id_valid_r;
    assign id_pc_o             = id_pc_r;
    assign id_inst_o           = id_inst_r;
    assign id_exception_type_o = id_exc_r;

    postif_id_chk u_chk (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush_i),
        .state     (state_r),
        .beat      (beat_s),
        .buf_valid (skid_valid_s)
    );

endmodule

// File: tb/tb_postif_id.sv
// Directed bench for postif_id: hit stream, id stall skid, cache miss, flush, fetch
// exception and reset while the buffer is full.
module tb_postif_id;

    logic        clk;
    logic        resetn;
    logic        fetch_valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] exception_type_i;
    logic        inst_stall_i;
    logic        id_stall_i;
    logic        flush_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_exception_type_o;
    logic        stall_req_o;

    int n_checks = 0;
    int n_errors = 0;

    postif_id dut (
        .clk                 (clk),
        .resetn              (resetn),
        .fetch_valid_i       (fetch_valid_i),
        .pc_i                (pc_i),
        .inst_i              (inst_i),
        .exception_type_i    (exception_type_i),
        .inst_stall_i        (inst_stall_i),
        .id_stall_i          (id_stall_i),
        .flush_i             (flush_i),
        .id_valid_o          (id_valid_o),
        .id_pc_o             (id_pc_o),
        .id_inst_o           (id_inst_o),
        .id_exception_type_o (id_exception_type_o),
        .stall_req_o         (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] exc, input logic istall, input logic idstall,
                         input logic flush);
        fetch_valid_i    = fv;
        pc_i             = pc;
        inst_i           = inst;
        exception_type_i = exc;
        inst_stall_i     = istall;
        id_stall_i       = idstall;
        flush_i          = flush;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [31:0] exc);
        check({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, v});
        check({tag, ".pc"}, id_pc_o, pc);
        check({tag, ".inst"}, id_inst_o, inst);
        check({tag, ".exc"}, id_exception_type_o, exc);
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        check_id("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("idle.stall", {31'd0, stall_req_o}, 32'd0);

        // Hit stream, id free
        drive(1'b1, 32'hBFC0_0000, 32'h2401_0001, 32'h0, 1'b0, 1'b0, 1'b0);
        check("hit0.stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check_id("hit0", 1'b1, 32'hBFC0_0000, 32'h2401_0001, 32'h0);
        drive(1'b1, 32'hBFC0_0004, 32'h2401_0002, 32'h0, 1'b0, 1'b0, 1'b0);
        check("hit1.stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check_id("hit1", 1'b1, 32'hBFC0_0004, 32'h2401_0002, 32'h0);

        // Return during id stall: beat is buffered, id holds for three stalled cycles
        drive(1'b1, 32'hBFC0_0008, 32'h3C1D_8000, 32'h0, 1'b0, 1'b1, 1'b0);
        check("skid.stall_in", {31'd0, stall_req_o}, 32'd1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            check("skid.stall_hold", {31'd0, stall_req_o}, 32'd1);
            cyc();
            check_id("skid.hold", 1'b1, 32'hBFC0_0004, 32'h2401_0002, 32'h0);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("skid.stall_full", {31'd0, stall_req_o}, 32'd1);
        cyc();
        check_id("skid.out", 1'b1, 32'hBFC0_0008, 32'h3C1D_8000, 32'h0);
        check("skid.stall_after", {31'd0, stall_req_o}, 32'd0);

        // Cache miss for five cycles, then the return
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hBFC0_000C, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
            check("miss.stall", {31'd0, stall_req_o}, 32'd1);
            cyc();
            check("miss.bubble", {31'd0, id_valid_o}, 32'd0);
            check("miss.nop", id_inst_o, 32'h0);
        end
        drive(1'b1, 32'hBFC0_000C, 32'h8FA4_0000, 32'h0, 1'b0, 1'b0, 1'b0);
        check("miss.ret_stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check_id("miss.ret", 1'b1, 32'hBFC0_000C, 32'h8FA4_0000, 32'h0);

        // Flush with a miss outstanding; the stale return must be dropped
        drive(1'b1, 32'hBFC0_0010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("flush.stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check("flush.valid", {31'd0, id_valid_o}, 32'd0);
        drive(1'b1, 32'hBFC0_0010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("disc.stall_wait", {31'd0, stall_req_o}, 32'd1);
        cyc();
        check("disc.valid_wait", {31'd0, id_valid_o}, 32'd0);
        drive(1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        check("disc.stall_ret", {31'd0, stall_req_o}, 32'd1);
        cyc();
        check_id("disc.drop", 1'b0, 32'hBFC0_000C, 32'h0, 32'h0);
        drive(1'b1, 32'hBFC0_0380, 32'h4080_6000, 32'h0, 1'b0, 1'b0, 1'b0);
        check("disc.next_stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check_id("disc.next", 1'b1, 32'hBFC0_0380, 32'h4080_6000, 32'h0);

        // Fetch exception (AdEL, bit 4) while the cache reports stall
        drive(1'b1, 32'h0000_0003, 32'h1234_5678, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
        check("exc.stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check_id("exc", 1'b1, 32'h0000_0003, 32'h0, 32'h0000_0010);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_id("exc.bubble", 1'b0, 32'h0000_0003, 32'h0, 32'h0);

        // Reset while the buffer is full
        drive(1'b1, 32'hBFC0_0020, 32'h1111_1111, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("rstfull.stall", {31'd0, stall_req_o}, 32'd1);
        resetn = 1'b0;
        cyc();
        check_id("rstfull", 1'b0, 32'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rstfull.empty_stall", {31'd0, stall_req_o}, 32'd0);
        cyc();
        check_id("rstfull.after", 1'b0, 32'h0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
